ntsc_sync_gen: RTL

- Interlaced NTSC 525/59.94 timing generator for the square-pixel (780 clocks/line) video path.
- Runs on the fast system clock, gated by the pixel-rate enable.
- Produces composite sync, blanking, burst gate and active-video strobes, plus aligned pixel/line counters and the once-per-frame HVcy pulse.
- Sits directly upstream of the video pattern/colour stage, which renders pixels and converts these strobes into sample levels.

---
 rtl/ntsc_sync_gen.sv | 103 ++++++++++
 1 files changed

// File: rtl/ntsc_sync_gen.sv
// ntsc_sync_gen: interlaced 525-line NTSC sync/blank/burst/active strobe generator
// with pixel/line counters, registered one pixel tick after decode.
module ntsc_sync_gen #(
    parameter int C_H_TOTAL  = 780,
    parameter int C_HSYNC_W  = 58,
    parameter int C_EQ_W     = 28,
    parameter int C_BROAD_W  = 333,
    parameter int C_BURST_ST = 65,
    parameter int C_BURST_W  = 31,
    parameter int C_ACT_ST   = 122,
    parameter int C_ACT_W    = 640,
    parameter int C_V_ACT    = 21,
    parameter int C_V_LINES  = 240,
    parameter int C_PROG     = 0
) (
    input  logic       CK_i,
    input  logic       XARST_i,
    input  logic       CK_EE_i,
    output logic       SYNC_o,
    output logic       BLANK_o,
    output logic       BURST_o,
    output logic       ACT_o,
    output logic       FIELD_o,
    output logic       HVcy_o,
    output logic [9:0] HCTRs_o,
    output logic [9:0] VCTRs_o
);
    localparam logic        PROG      = (C_PROG != 0);
    localparam logic [9:0]  H_LAST    = 10'(C_H_TOTAL - 1);
    localparam logic [9:0]  H_HALF    = 10'(C_H_TOTAL / 2);
    localparam logic [9:0]  L_LAST    = PROG ? 10'd261 : 10'd524;
    localparam logic [9:0]  HSYNC_W   = 10'(C_HSYNC_W);
    localparam logic [9:0]  EQ_W      = 10'(C_EQ_W);
    localparam logic [9:0]  BROAD_W   = 10'(C_BROAD_W);
    localparam logic [9:0]  BURST_ST  = 10'(C_BURST_ST);
    localparam logic [9:0]  BURST_END = 10'(C_BURST_ST + C_BURST_W);
    localparam logic [9:0]  ACT_ST    = 10'(C_ACT_ST);
    localparam logic [9:0]  ACT_END   = 10'(C_ACT_ST + C_ACT_W);
    localparam logic [9:0]  V1_ST     = 10'(C_V_ACT);
    localparam logic [9:0]  V1_END    = 10'(C_V_ACT + C_V_LINES);
    localparam logic [9:0]  V2_ST     = 10'(C_V_ACT + 263);
    localparam logic [9:0]  V2_END    = 10'(C_V_ACT + 263 + C_V_LINES);
    localparam logic [10:0] HL_F2     = 11'd525;

    logic [9:0]  h_q, h_d, l_q, l_d, hh;
    logic [10:0] hl, rel;
    logic        upper, f2, vint, broad, sync, burst, act, h_wrap;
    logic        sync_q, burst_q, act_q, field_q, hvcy_q;
    logic [9:0]  hctr_q, vctr_q;

    always_comb begin
        upper  = h_q >= H_HALF;
        hh     = upper ? h_q - H_HALF : h_q;
        hl     = {l_q, upper};
        f2     = !PROG && hl >= HL_F2;
        // Field 2 reuses the field-1 vertical pattern offset by 525 half-lines
        rel    = f2 ? hl - HL_F2 : hl;
        vint   = rel < 11'd18;
        broad  = rel >= 11'd6 && rel < 11'd12;
        sync   = vint ? hh < (broad ? BROAD_W : EQ_W) : (!hl[0] && hh < HSYNC_W);
        burst  = !vint && !hl[0] && h_q >= BURST_ST && h_q < BURST_END;
        act    = h_q >= ACT_ST && h_q < ACT_END &&
                 ((l_q >= V1_ST && l_q < V1_END) || (!PROG && l_q >= V2_ST && l_q < V2_END));
        h_wrap = h_q >= H_LAST;
        h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
        l_d    = h_wrap ? (l_q >= L_LAST ? 10'd0 : l_q + 10'd1) : (l_q > L_LAST ? 10'd0 : l_q);
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            h_q     <= '0;
            l_q     <= '0;
            sync_q  <= 1'b0;
            burst_q <= 1'b0;
            act_q   <= 1'b0;
            field_q <= 1'b0;
            hvcy_q  <= 1'b0;
            hctr_q  <= '0;
            vctr_q  <= '0;
        end else begin
            hvcy_q <= CK_EE_i && h_q == 10'd0 && l_q == 10'd0;
            if (CK_EE_i) begin
                h_q     <= h_d;
                l_q     <= l_d;
                sync_q  <= sync;
                burst_q <= burst;
                act_q   <= act;
                field_q <= f2;
                hctr_q  <= h_q;
                vctr_q  <= l_q;
            end
        end
    end

    assign SYNC_o  = sync_q;
    assign BLANK_o = ~act_q;
    assign BURST_o = burst_q;
    assign ACT_o   = act_q;
    assign FIELD_o = field_q;
    assign HVcy_o  = hvcy_q;
    assign HCTRs_o = hctr_q;
    assign VCTRs_o = vctr_q;
endmodule
